// File: rtl/game_state_ctrl.sv
// game_state_ctrl: bird/pipe/boundary collision, pipe-pass scoring and game FSM.
// A hit is registered once in hit_r before the FSM reacts, so game_end lags the offending input by two ticks.
module game_state_ctrl #(
  parameter int BIRD_X      = 100,
  parameter int BIRD_HALF   = 14,
  parameter int PIPE_HALF_W = 20,
  parameter int GAP_HALF    = 60,
  parameter int Y_MIN       = 15,
  parameter int Y_MAX       = 465,
  parameter int HIT_HOLD    = 10,
  parameter int MAX_SCORE   = 999
) (
  input  logic       clk10,
  input  logic       clr,
  input  logic       start,
  input  logic [9:0] bird_y_pos,
  input  logic [9:0] pipe_x,
  input  logic [9:0] gap_y,
  output logic       game_end,
  output logic       playing,
  output logic       hit_flash,
  output logic [9:0] score
);
  localparam int HW = $clog2(HIT_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HIT_HOLD - 1);
  localparam logic signed [10:0] BX = 11'(BIRD_X);
  localparam logic signed [10:0] BH = 11'(BIRD_HALF);
  localparam logic signed [10:0] GH = 11'(GAP_HALF);
  localparam logic signed [10:0] XW = 11'(PIPE_HALF_W + BIRD_HALF);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX);
  localparam logic [9:0] BXU = 10'(BIRD_X);
  localparam logic [9:0] MS = 10'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
  state_t state;
  logic hit_r;
  logic [9:0] pipe_x_prev;
  logic [HW-1:0] hold_cnt;

  logic signed [10:0] by, px, gy, d, dx, bt_raw, gt_raw, bird_top, bird_bot, gap_top, gap_bot;
  logic x_ovl, y_out, bnd, hit_now, pass;

  assign by = {1'b0, bird_y_pos};
  assign px = {1'b0, pipe_x};
  assign gy = {1'b0, gap_y};
  assign d = px - BX;
  assign dx = d[10] ? -d : d;
  assign x_ovl = dx < XW;
  assign bt_raw = by - BH;
  assign gt_raw = gy - GH;
  assign bird_top = bt_raw[10] ? '0 : bt_raw;
  assign gap_top = gt_raw[10] ? '0 : gt_raw;
  assign bird_bot = by + BH;
  assign gap_bot = gy + GH;
  assign y_out = (bird_top < gap_top) | (bird_bot > gap_bot);
  assign bnd = (by <= YLO) | (by >= YHI);
  assign hit_now = (x_ovl & y_out) | bnd;
  assign pass = (pipe_x_prev > BXU) & (pipe_x <= BXU);

  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      game_end <= 1'b0;
      playing <= 1'b0;
      hit_flash <= 1'b0;
      score <= '0;
      hit_r <= 1'b0;
      pipe_x_prev <= '0;
      hold_cnt <= '0;
    end else begin
      pipe_x_prev <= pipe_x;
      hit_r <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= PLAY;
          playing <= 1'b1;
          score <= '0;
        end
        PLAY: begin
          hit_r <= hit_now & ~hit_r;
          if (pass && !hit_now && !hit_r && score != MS) score <= score + 10'd1;
          if (hit_r) begin
            state <= HIT;
            playing <= 1'b0;
            game_end <= 1'b1;
            hit_flash <= 1'b0;
            hold_cnt <= '0;
          end
        end
        HIT: if (hold_cnt == HOLD_LAST) begin
          state <= OVER;
          hit_flash <= 1'b0;
        end else begin
          hit_flash <= ~hit_flash;
          hold_cnt <= hold_cnt + 1'b1;
        end
        OVER: if (start) begin
          state <= IDLE;
          game_end <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: scoreboard bench; expected outputs are queued per tick and compared after the edge.
module tb_game_state_ctrl;
  logic clk10 = 1'b0;
  logic clr, start;
  logic [9:0] bird_y_pos, pipe_x, gap_y, score;
  logic game_end, playing, hit_flash;

  typedef struct {int ge; int pl; int hf; int sc;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  game_state_ctrl dut (
    .clk10(clk10), .clr(clr), .start(start), .bird_y_pos(bird_y_pos), .pipe_x(pipe_x), .gap_y(gap_y),
    .game_end(game_end), .playing(playing), .hit_flash(hit_flash), .score(score)
  );

  always #5 clk10 = ~clk10;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input int by, input int px, input int gy,
                      input int ge, input int pl, input int hf, input int sc);
    exp_t e;
    start = st;
    bird_y_pos = 10'(by);
    pipe_x = 10'(px);
    gap_y = 10'(gy);
    q.push_back('{ge, pl, hf, sc});
    @(posedge clk10);
    #1;
    e = q.pop_front();
    chk("game_end", 32'(game_end), e.ge);
    chk("playing", 32'(playing), e.pl);
    if (e.hf >= 0) chk("hit_flash", 32'(hit_flash), e.hf);
    chk("score", 32'(score), e.sc);
  endtask

  // From the first HIT tick: nine more blinking HIT ticks, OVER, then start held through IDLE into PLAY.
  task automatic finish_round(input int sc);
    for (int k = 1; k <= 9; k++) step(0, 240, 400, 240, 1, 0, k % 2, sc);
    step(0, 240, 400, 240, 1, 0, 0, sc);
    step(1, 240, 400, 240, 0, 0, 0, sc);
    step(1, 240, 400, 240, 0, 1, 0, 0);
  endtask

  initial begin
    clr = 1'b0;
    start = 1'b0;
    bird_y_pos = 10'd240;
    pipe_x = 10'd300;
    gap_y = 10'd240;
    #12;
    chk("rst_game_end", 32'(game_end), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_hit_flash", 32'(hit_flash), 0);
    chk("rst_score", 32'(score), 0);
    @(negedge clk10);
    clr = 1'b1;
    step(0, 240, 300, 240, 0, 0, 0, 0);
    step(1, 240, 300, 240, 0, 1, 0, 0);
    for (int p = 294; p >= 96; p -= 6) step(0, 240, p, 240, 0, 1, 0, (p <= 100) ? 1 : 0);
    step(0, 240, 90, 240, 0, 1, 0, 1);
    step(0, 240, 5, 240, 0, 1, 0, 1);
    step(0, 240, 620, 240, 0, 1, 0, 1);
    step(0, 240, 614, 240, 0, 1, 0, 1);
    // pass crossing coincides with bird_bot > gap_bot
    step(0, 240, 106, 240, 0, 1, 0, 1);
    step(0, 240, 100, 180, 0, 1, 0, 1);
    step(0, 240, 94, 240, 1, 0, 0, 1);
    finish_round(1);
    step(0, 240, 106, 240, 0, 1, 0, 0);
    step(0, 240, 100, 240, 0, 1, 0, 1);
    step(0, 240, 110, 100, 0, 1, 0, 1);
    step(0, 240, 110, 100, 1, 0, 0, 1);
    finish_round(1);
    step(0, 465, 400, 240, 0, 1, 0, 0);
    step(0, 240, 400, 240, 1, 0, 0, 0);
    finish_round(0);
    step(0, 15, 400, 240, 0, 1, 0, 0);
    step(0, 240, 400, 240, 1, 0, 0, 0);
    finish_round(0);
    step(0, 16, 400, 240, 0, 1, 0, 0);
    step(0, 464, 400, 240, 0, 1, 0, 0);
    step(0, 240, 400, 240, 0, 1, 0, 0);
    step(0, 240, 400, 240, 0, 1, 0, 0);
    step(0, 240, 101, 240, 0, 1, 0, 0);
    for (int i = 1; i <= 1002; i++) begin
      step(0, 240, 100, 240, 0, 1, 0, (i > 999) ? 999 : i);
      step(0, 240, 101, 240, 0, 1, 0, (i > 999) ? 999 : i);
    end
    step(0, 465, 101, 240, 0, 1, 0, 999);
    step(0, 240, 101, 240, 1, 0, 0, 999);
    step(0, 240, 101, 240, 1, 0, 1, 999);
    #2 clr = 1'b0;
    #1;
    chk("clr_game_end", 32'(game_end), 0);
    chk("clr_playing", 32'(playing), 0);
    chk("clr_hit_flash", 32'(hit_flash), 0);
    chk("clr_score", 32'(score), 0);
    #1 clr = 1'b1;
    step(1, 240, 400, 240, 0, 1, 0, 0);
    step(0, 240, 400, 240, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
